// File: rtl/idma_mchan_dispatch.sv
// idma_mchan_dispatch
//   Arbitrates NumChannels iDMA request streams onto one registered mid-end
//   request port. Assigns per-channel transfer IDs and retires in-order
//   completions through a channel-tag FIFO. Reports per-channel
//   start/done/busy/error status.
//
// Configuration macro:
//   IDMA_MCHAN_FIXED_PRIO_EN - fixed priority (lowest index wins) instead of
//                              round-robin arbitration.
//
// Ports:
//   clk_i, rst_i, clear_i   clock, sync active-high reset, sync soft clear
//   ch_req_i / ch_valid_i   per-channel request payload and valid
//   ch_ready_o              per-channel accept (combinational, one-hot or zero)
//   ch_id_o                 ID the next accepted transfer of each channel gets
//   ch_done_id_o            ID of the last retired transfer of each channel
//   ch_start_o / ch_done_o  one-cycle accept / retire pulses
//   ch_busy_o / ch_error_o  outstanding-transfer flag / sticky error
//   me_req_o / me_valid_o / me_ready_i                    mid-end request port
//   me_rsp_valid_i / me_rsp_error_i / me_rsp_ready_o      mid-end completion port
module idma_mchan_dispatch #(
    parameter int unsigned NumChannels   = 2,
    parameter int unsigned ReqWidth      = 256,
    parameter int unsigned IdWidth       = 8,
    parameter int unsigned InflightDepth = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic [NumChannels*ReqWidth-1:0]  ch_req_i,
    input  logic [NumChannels-1:0]           ch_valid_i,
    output logic [NumChannels-1:0]           ch_ready_o,
    output logic [NumChannels*IdWidth-1:0]   ch_id_o,
    output logic [NumChannels*IdWidth-1:0]   ch_done_id_o,
    output logic [NumChannels-1:0]           ch_start_o,
    output logic [NumChannels-1:0]           ch_done_o,
    output logic [NumChannels-1:0]           ch_busy_o,
    output logic [NumChannels-1:0]           ch_error_o,
    output logic [ReqWidth-1:0]              me_req_o,
    output logic                             me_valid_o,
    input  logic                             me_ready_i,
    input  logic                             me_rsp_valid_i,
    input  logic                             me_rsp_error_i,
    output logic                             me_rsp_ready_o
);

    localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned PtrW = (InflightDepth > 1) ? $clog2(InflightDepth) : 1;
    localparam int unsigned CntW = $clog2(InflightDepth + 1);

    // ID sequence: 1, 2, ..., 2^IdWidth-1, 1, ... (0 never reused after reset)
    function automatic logic [IdWidth-1:0] id_incr(input logic [IdWidth-1:0] id);
        return (id == '1) ? IdWidth'(1) : id + IdWidth'(1);
    endfunction

    // Tag FIFO pointer advance with wrap for non-power-of-two depths
    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(InflightDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    logic [ReqWidth-1:0]    me_req_q;
    logic                   me_valid_q;
    logic [ChW-1:0]         tag_mem [InflightDepth];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        cnt_q;
    logic [IdWidth-1:0]     next_id_q [NumChannels];
    logic [IdWidth-1:0]     done_id_q [NumChannels];
    logic [CntW-1:0]        outst_q   [NumChannels];
    logic [NumChannels-1:0] start_q, done_q, error_q;

    logic                   stage_free, fifo_full, fifo_empty, can_accept, accept, rsp_fire;
    logic                   grant_vld;
    logic [ChW-1:0]         grant_idx, head_ch;
    logic [NumChannels-1:0] grant_oh, ret_oh;
    logic [ReqWidth-1:0]    req_sel;

    assign stage_free = !me_valid_q || me_ready_i;
    assign fifo_full  = (cnt_q == CntW'(InflightDepth));
    assign fifo_empty = (cnt_q == '0);
    // Full is judged on the registered count: a pop this cycle does not free a slot yet
    assign can_accept = stage_free && !fifo_full;
    assign accept     = can_accept && grant_vld;
    assign head_ch    = tag_mem[rd_ptr_q];
    assign rsp_fire   = me_rsp_valid_i && !fifo_empty;

    assign grant_oh   = NumChannels'(1) << grant_idx;
    assign ret_oh     = rsp_fire ? (NumChannels'(1) << head_ch) : '0;

`ifdef IDMA_MCHAN_FIXED_PRIO_EN
    // Lowest valid channel index wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
            if (ch_valid_i[ChW'(i)]) begin
                grant_vld = 1'b1;
                grant_idx = ChW'(i);
            end
        end
    end
`else
    logic [ChW-1:0] rr_ptr_q;
    int             cand;

    // Round-robin: first valid channel at or after the pointer
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 0; i < int'(NumChannels); i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= int'(NumChannels)) cand = cand - int'(NumChannels);
            if (!grant_vld && ch_valid_i[ChW'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = ChW'(cand);
            end
        end
    end

    // Pointer moves past the granted channel only on an actual accept
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (grant_idx == ChW'(NumChannels - 1)) ? '0 : grant_idx + ChW'(1);
        end
    end
`endif

    // Payload mux for the granted channel
    always_comb begin
        req_sel = '0;
        for (int c = 0; c < int'(NumChannels); c++) begin
            if (grant_idx == ChW'(c)) req_sel = ch_req_i[c*ReqWidth +: ReqWidth];
        end
    end

    // Tag storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge clk_i) begin
        if (accept) tag_mem[wr_ptr_q] <= grant_idx;
    end

    // Output stage, tag FIFO control and per-channel tracking
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            me_req_q   <= '0;
            me_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            start_q    <= '0;
            done_q     <= '0;
            error_q    <= '0;
            for (int c = 0; c < int'(NumChannels); c++) begin
                next_id_q[c] <= IdWidth'(1);
                done_id_q[c] <= '0;
                outst_q[c]   <= '0;
            end
        end else begin
            if (accept) begin
                me_req_q   <= req_sel;
                me_valid_q <= 1'b1;
            end else if (me_ready_i) begin
                me_valid_q <= 1'b0;
            end

            if (accept)   wr_ptr_q <= ptr_incr(wr_ptr_q);
            if (rsp_fire) rd_ptr_q <= ptr_incr(rd_ptr_q);
            if (accept && !rsp_fire)      cnt_q <= cnt_q + CntW'(1);
            else if (!accept && rsp_fire) cnt_q <= cnt_q - CntW'(1);

            start_q <= ch_ready_o;
            done_q  <= ret_oh;

            for (int c = 0; c < int'(NumChannels); c++) begin
                if (ch_ready_o[c]) next_id_q[c] <= id_incr(next_id_q[c]);
                if (ret_oh[c])     done_id_q[c] <= id_incr(done_id_q[c]);
                if (ret_oh[c] && me_rsp_error_i) error_q[c] <= 1'b1;
                // Accept and retire on the same channel cancel out
                if (ch_ready_o[c] && !ret_oh[c])      outst_q[c] <= outst_q[c] + CntW'(1);
                else if (!ch_ready_o[c] && ret_oh[c]) outst_q[c] <= outst_q[c] - CntW'(1);
            end
        end
    end

    assign ch_ready_o     = accept ? grant_oh : '0;
    assign me_req_o       = me_req_q;
    assign me_valid_o     = me_valid_q;
    assign me_rsp_ready_o = !fifo_empty;
    assign ch_start_o     = start_q;
    assign ch_done_o      = done_q;
    assign ch_error_o     = error_q;

    for (genvar c = 0; c < int'(NumChannels); c++) begin : g_ch_out
        assign ch_id_o[c*IdWidth +: IdWidth]      = next_id_q[c];
        assign ch_done_id_o[c*IdWidth +: IdWidth] = done_id_q[c];
        assign ch_busy_o[c]                       = (outst_q[c] != '0);
    end

endmodule
